// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: PC, single-outstanding imem request,
// one-entry {instr, pc} buffer toward decode, branch redirect.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_t;

endpackage

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_base,
  input  logic [31:0] redirect_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign_err
);

  localparam logic [31:0] PC0 = {RESET_PC[31:2], 2'b00};

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drop_q, drop_d;
  if_id_t       buf_q, buf_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;

  logic [31:0]  target;
  logic [31:0]  tgt_pc;
  logic         tgt_mis;

  // Branch target, word-aligned, with misalignment detect.
  always_comb begin
    target  = redirect_base + redirect_imm;
    tgt_pc  = {target[31:2], 2'b00};
    tgt_mis = |target[1:0];
  end

  // Next-state and datapath updates for the fetch FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    buf_d   = buf_q;
    valid_d = valid_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_d  = tgt_pc;
          err_d = err_q | tgt_mis;
          if (imem_rvalid) begin
            state_d = REQ;
          end else begin
            state_d = DROP;
            drop_d  = pc_q;
          end
        end else if (imem_rvalid) begin
          buf_d   = '{instr: imem_rdata, pc: pc_q};
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          pc_d    = tgt_pc;
          err_d   = err_q | tgt_mis;
          state_d = REQ;
        end else if (out_ready) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      DROP: begin
        if (redirect_valid) begin
          pc_d  = tgt_pc;
          err_d = err_q | tgt_mis;
          if (imem_rvalid) state_d = REQ;
        end else if (imem_rvalid) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= PC0;
      drop_q  <= PC0;
      buf_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // DROP keeps presenting the abandoned address until it is answered.
  always_comb begin
    imem_req     = (state_q == REQ) || (state_q == DROP);
    imem_addr    = (state_q == DROP) ? drop_q : pc_q;
    out_valid    = valid_q;
    out_instr    = buf_q.instr;
    out_pc       = buf_q.pc;
    misalign_err = err_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic
// compared against a transaction-level model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_base = '0;
  logic [31:0] redirect_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_err;

  int tests = 0;
  int failed = 0;

  // model: started, request owed, owed answer is junk, etc.
  bit          m_started;
  bit          m_owed;
  bit          m_junk;
  logic [31:0] m_pc;
  logic [31:0] m_haddr;
  bit          m_bv;
  logic [31:0] m_bi;
  logic [31:0] m_bp;
  bit          m_err;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_base(redirect_base),
    .redirect_imm(redirect_imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0;
    m_owed    = 0;
    m_junk    = 0;
    m_pc      = 32'h0;
    m_haddr   = 32'h0;
    m_bv      = 0;
    m_bi      = 32'h0;
    m_bp      = 32'h0;
    m_err     = 0;
  endtask

  task automatic model_edge(input bit rv, input logic [31:0] rd,
                            input bit rdv, input logic [31:0] base,
                            input logic [31:0] imm, input bit rdy);
    logic [31:0] t;
    logic [31:0] ta;
    t  = base + imm;
    ta = t & 32'hFFFF_FFFC;
    if (!m_started) begin
      m_started = 1;
      m_owed    = 1;
      m_junk    = 0;
    end else if (m_owed && !m_junk) begin
      if (rdv) begin
        if (t[1:0] != 2'b00) m_err = 1;
        if (!rv) begin
          m_junk  = 1;
          m_haddr = m_pc;
        end
        m_pc = ta;
      end else if (rv) begin
        m_bv   = 1;
        m_bi   = rd;
        m_bp   = m_pc;
        m_pc   = m_pc + 32'd4;
        m_owed = 0;
      end
    end else if (m_owed) begin
      if (rdv) begin
        if (t[1:0] != 2'b00) m_err = 1;
        m_pc = ta;
      end
      if (rv) m_junk = 0;
    end else begin
      if (rdv) begin
        if (t[1:0] != 2'b00) m_err = 1;
        m_pc   = ta;
        m_bv   = 0;
        m_owed = 1;
      end else if (rdy) begin
        m_bv   = 0;
        m_owed = 1;
      end
    end
  endtask

  task automatic check_all();
    check("imem_req", 32'(imem_req), 32'(m_owed));
    check("imem_addr", imem_addr, m_junk ? m_haddr : m_pc);
    check("out_valid", 32'(out_valid), 32'(m_bv));
    check("misalign_err", 32'(misalign_err), 32'(m_err));
    if (m_bv) begin
      check("out_instr", out_instr, m_bi);
      check("out_pc", out_pc, m_bp);
    end
  endtask

  task automatic step(input bit rv, input logic [31:0] rd,
                      input bit rdv, input logic [31:0] base,
                      input logic [31:0] imm, input bit rdy);
    imem_rvalid    = rv;
    imem_rdata     = rd;
    redirect_valid = rdv;
    redirect_base  = base;
    redirect_imm   = imm;
    out_ready      = rdy;
    @(posedge clk);
    model_edge(rv, rd, rdv, base, imm, rdy);
    #1;
    check_all();
  endtask

  task automatic idle(input bit rv, input bit rdy);
    step(rv, $urandom, 1'b0, 32'h0, 32'h0, rdy);
  endtask

  task automatic do_reset();
    #2;
    rst_n          = 1'b0;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    #1;
    model_reset();
    check("rst imem_req", 32'(imem_req), 32'h0);
    check("rst imem_addr", imem_addr, 32'h0);
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst out_instr", out_instr, 32'h0);
    check("rst out_pc", out_pc, 32'h0);
    check("rst misalign", 32'(misalign_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    check("rst imem_req", 32'(imem_req), 32'h0);
    check("rst imem_addr", imem_addr, 32'h0);
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst misalign", 32'(misalign_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: first fetch and handoff
    idle(1'b0, 1'b0);
    check("t1 req", 32'(imem_req), 32'h1);
    check("t1 addr", imem_addr, 32'h0);
    idle(1'b0, 1'b0);
    step(1'b1, 32'h0050_0093, 1'b0, 32'h0, 32'h0, 1'b0);
    check("t1 instr", out_instr, 32'h0050_0093);
    check("t1 pc", out_pc, 32'h0);
    idle(1'b0, 1'b1);
    check("t1 next addr", imem_addr, 32'h4);

    // 2: backpressure
    step(1'b1, 32'h1111_2222, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b1, 1'b0);
      check("t2 stall req", 32'(imem_req), 32'h0);
    end
    idle(1'b0, 1'b1);
    check("t2 next addr", imem_addr, 32'h8);

    // 3: redirect in HOLD to 0x08
    step(1'b1, 32'h3333_4444, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 32'h10, 32'hFFFF_FFF8, 1'b0);
    check("t3 valid", 32'(out_valid), 32'h0);
    check("t3 addr", imem_addr, 32'h8);
    step(1'b1, 32'h5555_6666, 1'b0, 32'h0, 32'h0, 1'b0);
    check("t3 out_pc", out_pc, 32'h8);

    // 4: redirect while request to 0x20 is outstanding
    step(1'b0, 32'h0, 1'b1, 32'h18, 32'h8, 1'b0);
    step(1'b0, 32'h0, 1'b1, 32'h20, 32'h40, 1'b0);
    check("t4 addr0", imem_addr, 32'h20);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check("t4 addr2", imem_addr, 32'h20);
    idle(1'b1, 1'b0);
    check("t4 valid", 32'(out_valid), 32'h0);
    check("t4 addr", imem_addr, 32'h60);

    // 5: redirect coincident with rvalid in REQ
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0, 32'h100, 1'b0);
    check("t5 valid", 32'(out_valid), 32'h0);
    check("t5 addr", imem_addr, 32'h100);

    // 6: misaligned redirect, then reset mid-DROP
    step(1'b0, 32'h0, 1'b1, 32'h0, 32'h6, 1'b0);
    check("t6 err", 32'(misalign_err), 32'h1);
    idle(1'b1, 1'b0);
    check("t6 addr", imem_addr, 32'h4);
    check("t6 err sticky", 32'(misalign_err), 32'h1);
    step(1'b0, 32'h0, 1'b1, 32'h0, 32'h6, 1'b0);
    do_reset();

    // wrap of pc+4 at top of memory
    idle(1'b0, 1'b0);
    step(1'b1, 32'h0, 1'b1, 32'hFFFF_FFF0, 32'hC, 1'b0);
    check("wrap addr", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(1'b0, 1'b1);
    check("wrap next", imem_addr, 32'h0);
    check("wrap err", 32'(misalign_err), 32'h0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] imm;
      if ($urandom_range(0, 599) == 0) do_reset();
      if ($urandom_range(0, 7) == 0) imm = $urandom;
      else imm = ($urandom_range(0, 255) * 4) - 32'd512;
      step(1'($urandom_range(0, 1)), $urandom,
           $urandom_range(0, 5) == 0, $urandom & 32'hFFFF_FFFC,
           imm, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
